// File: rtl/rca_seq_arbiter_if.sv
// -----------------------------------------------------------------------------
// rca_seq_arbiter_if
// Bundles the two requester channels and the result/flag delivery bus of the
// shared byte-serial add/sub unit.
//
// Signals:
//   req_0/a_0/b_0/sub_0   requester 0 request, operands, op (1 = A-B)
//   req_1/a_1/b_1/sub_1   requester 1, same meanings
//   grant[1:0]            one-hot operand-capture strobe
//   busy                  operation in flight
//   done/done_id          result-valid pulse and owning requester
//   result/carry_out/overflow  registered result and flags
//
// Modports:
//   master  client side (drives requests, observes grant/results)
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface rca_seq_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_0;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] b_0;
    logic             sub_0;
    logic             req_1;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] b_1;
    logic             sub_1;
    logic [1:0]       grant;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output req_0, a_0, b_0, sub_0,
        output req_1, a_1, b_1, sub_1,
        input  grant, busy, done, done_id, result, carry_out, overflow
    );

    modport slave (
        input  req_0, a_0, b_0, sub_0,
        input  req_1, a_1, b_1, sub_1,
        output grant, busy, done, done_id, result, carry_out, overflow
    );
endinterface

// File: rtl/rca_seq_arbiter.sv
// -----------------------------------------------------------------------------
// rca_seq_arbiter
// Shares one 8-bit ripple-carry add/sub slice between two requesters. A granted
// operation is executed byte-serially, LSB slice first, with the carry held in
// a register between slices. Round-robin arbitration resolves ties.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (aborts any operation in flight)
//   bus   rca_seq_arbiter_if.slave: requests/operands in, grant/busy/done,
//         done_id, result, carry_out, overflow out
//
// Timing: grant in cycle T, slices in T+1..T+NSLICE, done pulse at T+NSLICE+1.
// -----------------------------------------------------------------------------
module rca_seq_arbiter #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    rca_seq_arbiter_if.slave bus
);
    localparam int NSLICE = WIDTH / 8;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;            // slice index within RUN
    logic [WIDTH-1:0] op_a;         // captured A
    logic [WIDTH-1:0] op_b;         // captured B' (already inverted for subtract)
    logic [WIDTH-1:0] work;         // working result, filled one byte per cycle
    logic             carry_q;      // carry into the current slice; seeded with cin
    logic             op_id;
    logic             last_winner;

    // Arbitration and slice datapath
    logic             any_req;
    logic             win;
    logic             win_sub;
    logic [8:0]       slice_sum;
    logic [WIDTH-1:0] work_next;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        any_req   = bus.req_0 | bus.req_1;
        win       = (bus.req_0 && bus.req_1) ? ~last_winner : bus.req_1;
        win_sub   = win ? bus.sub_1 : bus.sub_0;
        bus.grant = 2'b00;
        if (!rst && state == IDLE && any_req)
            bus.grant = win ? 2'b10 : 2'b01;

        slice_sum = {1'b0, op_a[8*int'(k) +: 8]}
                  + {1'b0, op_b[8*int'(k) +: 8]}
                  + {8'b0, carry_q};
        work_next = work;
        work_next[8*int'(k) +: 8] = slice_sum[7:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            op_a          <= '0;
            op_b          <= '0;
            work          <= '0;
            carry_q       <= 1'b0;
            op_id         <= 1'b0;
            last_winner   <= 1'b1;    // requester 0 wins the first tie
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.done_id   <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a        <= win ? bus.a_1 : bus.a_0;
                        op_b        <= win_sub ? ~(win ? bus.b_1 : bus.b_0)
                                               :  (win ? bus.b_1 : bus.b_0);
                        carry_q     <= win_sub;     // +1 completes two's complement
                        op_id       <= win;
                        last_winner <= win;
                        k           <= '0;
                        bus.busy    <= 1'b1;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    work    <= work_next;
                    carry_q <= slice_sum[8];
                    if (k == K_LAST) begin
                        // Publish on the way into DONE so the outputs are
                        // registered and valid for the whole done cycle.
                        bus.done      <= 1'b1;
                        bus.done_id   <= op_id;
                        bus.result    <= work_next;
                        bus.carry_out <= slice_sum[8];
                        bus.overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                         (work_next[WIDTH-1] != op_a[WIDTH-1]);
                        state         <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_seq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rca_seq_arbiter
// Directed stimulus for rca_seq_arbiter (WIDTH=32). A transaction-level model
// predicts every output each cycle from arbitration rules and plain integer
// arithmetic; literal expectations pin the model on the hand-computed cases.
// -----------------------------------------------------------------------------
module tb_rca_seq_arbiter;
    localparam int W      = 32;
    localparam int NSLICE = W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   cmp_en = 1'b0;

    rca_seq_arbiter_if #(.WIDTH(W)) bus ();

    rca_seq_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_run_left = 0;   // slice cycles still to go
    bit              m_done     = 0;
    bit              m_last     = 1;
    bit              p_id, p_co, p_ov;
    logic [W-1:0]    p_res;
    bit              m_id, m_co, m_ov;
    logic [W-1:0]    m_res = '0;

    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        longint unsigned ua, ub, ures;
        longint          sa, sb, sres;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            p_co = (ua >= ub);              // no borrow
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            p_co = (ures >= (64'd1 << W));
        end
        p_res = ures[W-1:0];
        p_ov  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_run_left = 0;
            m_done = 0;
            m_last = 1;
            m_id = 0; m_co = 0; m_ov = 0; m_res = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) begin
                m_done = 1;
                m_id = p_id; m_res = p_res; m_co = p_co; m_ov = p_ov;
            end
        end else if (bus.req_0 || bus.req_1) begin
            p_id = (bus.req_0 && bus.req_1) ? !m_last : bus.req_1;
            if (p_id) model_op(bus.a_1, bus.b_1, bus.sub_1);
            else      model_op(bus.a_0, bus.b_0, bus.sub_0);
            m_last = p_id;
            m_run_left = NSLICE;
        end
    end

    // Compare every cycle, mid-cycle
    always @(negedge clk) begin
        logic [1:0] eg;
        bit         idle, w;
        if (cmp_en) begin
            idle = (m_run_left == 0) && !m_done;
            w    = (bus.req_0 && bus.req_1) ? !m_last : bus.req_1;
            eg   = (!rst && idle && (bus.req_0 || bus.req_1)) ? (w ? 2'b10 : 2'b01) : 2'b00;
            check("m_grant",    64'(bus.grant),     64'(eg));
            check("m_busy",     64'(bus.busy),      64'(!idle));
            check("m_done",     64'(bus.done),      64'(m_done));
            check("m_done_id",  64'(bus.done_id),   64'(m_id));
            check("m_result",   64'(bus.result),    64'(m_res));
            check("m_carry",    64'(bus.carry_out), 64'(m_co));
            check("m_overflow", 64'(bus.overflow),  64'(m_ov));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_reqs();
        bus.req_0 = 0; bus.req_1 = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1; clear_reqs();
        repeat (n) begin @(posedge clk); #1; end
        rst = 0;
    endtask

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sub, input logic [1:0] eg, input logic [W-1:0] er,
                         input bit eco, input bit eov);
        int  t_g, t_d;
        bit  got;
        @(posedge clk); #1;
        if (id) begin bus.req_1 = 1; bus.a_1 = a; bus.b_1 = b; bus.sub_1 = sub; end
        else    begin bus.req_0 = 1; bus.a_0 = a; bus.b_0 = b; bus.sub_0 = sub; end
        got = 0; t_g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) begin got = 1; t_g = cyc; break; end
        end
        if (!got) check("grant_timeout", 64'(0), 64'(1));
        check("grant", 64'(bus.grant), 64'(eg));
        @(posedge clk); #1;
        clear_reqs();
        got = 0; t_d = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; t_d = cyc; break; end
        end
        if (!got) check("done_timeout", 64'(0), 64'(1));
        check("latency",  64'(t_d - t_g),        64'(NSLICE + 1));
        check("done_id",  64'(bus.done_id),      64'(id));
        check("result",   64'(bus.result),       64'(er));
        check("carry",    64'(bus.carry_out),    64'(eco));
        check("overflow", 64'(bus.overflow),     64'(eov));
    endtask

    initial begin
        int  g_t [4];
        logic [1:0] g_v [4];
        bit  d_id [4];
        int  ng, nd, n_done;
        bit  got;

        clear_reqs();
        bus.a_0 = '0; bus.b_0 = '0; bus.sub_0 = 0;
        bus.a_1 = '0; bus.b_1 = '0; bus.sub_1 = 0;

        // Reset: 2 cycles, then idle with no request
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        cmp_en = 1;
        @(negedge clk);
        check("rst_busy",   64'(bus.busy),   64'(0));
        check("rst_done",   64'(bus.done),   64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        repeat (3) @(negedge clk);
        check("idle_grant", 64'(bus.grant), 64'(0));
        check("idle_busy",  64'(bus.busy),  64'(0));

        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 2'b01, 32'h0000_0000, 1, 0);
        do_op(1, 32'h0000_0005, 32'h0000_0007, 1, 2'b10, 32'hFFFF_FFFE, 0, 0);
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 2'b01, 32'h8000_0000, 0, 1);
        do_op(1, 32'h8000_0000, 32'h0000_0001, 1, 2'b10, 32'h7FFF_FFFF, 1, 1);
        do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 0, 2'b01, 32'h2222_2221, 0, 0);

        // Contention: both requests held high continuously after reset
        do_reset(2);
        bus.req_0 = 1; bus.a_0 = 32'h0000_0010; bus.b_0 = 32'h0000_0020; bus.sub_0 = 0;
        bus.req_1 = 1; bus.a_1 = 32'h0000_0100; bus.b_1 = 32'h0000_0001; bus.sub_1 = 1;
        ng = 0; nd = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (bus.grant != 2'b00 && ng < 4) begin g_t[ng] = cyc; g_v[ng] = bus.grant; ng++; end
            if (bus.done && nd < 4) begin d_id[nd] = bus.done_id; nd++; end
        end
        check("cont_ngrant", 64'(ng), 64'(4));
        check("cont_ndone",  64'(nd), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < ng) check("cont_grant", 64'(g_v[i]), 64'((i % 2) ? 2'b10 : 2'b01));
            if (i < nd) check("cont_id",    64'(d_id[i]), 64'(i % 2));
            if (i > 0 && i < ng) check("cont_spacing", 64'(g_t[i] - g_t[i-1]), 64'(NSLICE + 2));
        end

        // Abort: rst for one cycle at T+2 of a requester-1 operation
        do_reset(2);
        bus.req_1 = 1; bus.a_1 = 32'h0000_0003; bus.b_1 = 32'h0000_0004; bus.sub_1 = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.grant != 2'b00) begin got = 1; break; end
        end
        if (!got) check("abort_grant_timeout", 64'(0), 64'(1));
        check("abort_grant", 64'(bus.grant), 64'(2'b10));
        @(posedge clk); #1;          // T+1
        clear_reqs();
        @(posedge clk); #1;          // T+2
        rst = 1;
        @(posedge clk); #1;          // T+3
        rst = 0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'(0));
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));

        // Tie after reset goes to requester 0
        bus.a_0 = 32'h0000_0009; bus.b_0 = 32'h0000_0009; bus.sub_0 = 1;
        do_op(0, 32'h0000_0009, 32'h0000_0009, 1, 2'b01, 32'h0000_0000, 1, 0);
        @(posedge clk); #1;
        bus.req_0 = 1; bus.req_1 = 1;
        bus.a_1 = 32'h0000_0002; bus.b_1 = 32'h0000_0003; bus.sub_1 = 0;
        bus.a_0 = 32'h0000_0001; bus.b_0 = 32'h0000_0001; bus.sub_0 = 0;
        @(negedge clk);
        check("tie_after_op0", 64'(bus.grant), 64'(2'b10));
        @(posedge clk); #1;
        clear_reqs();
        do_reset(1);
        bus.req_0 = 1; bus.req_1 = 1;
        @(negedge clk);
        check("tie_after_reset", 64'(bus.grant), 64'(2'b01));
        @(posedge clk); #1;
        clear_reqs();
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; break; end
        end
        if (!got) check("tie_done_timeout", 64'(0), 64'(1));
        check("tie_done_id", 64'(bus.done_id), 64'(0));
        check("tie_result",  64'(bus.result),  64'(32'h0000_0002));

        repeat (3) @(negedge clk);
        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
